count_bcd_display: RTL

Downstream display stage for the 10-bit up-counter. It consumes the raw binary count and converts it to decimal with a sequential shift-add-3 (double-dabble) engine. It drives four active-low seven-segment digits (HEX3..HEX0) on the MAX10 board, with optional leading-zero blanking. The count originates in the divided-clock domain, so a stability filter qualifies it before each conversion starts.

---
 rtl/count_bcd_display_pkg.sv | 32 +++
 rtl/count_bcd_display_if.sv | 24 ++
 rtl/count_bcd_display_seg7_decode.sv | 30 +++
 rtl/count_bcd_display.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/count_bcd_display_pkg.sv
// Shared display definitions: active-low seven-segment codes, FSM encoding,
// and the double-dabble digit correction.
package count_bcd_display_pkg;

   localparam int unsigned SEG_W   = 8;
   localparam int unsigned DIGIT_W = 4;

   // Segment order {dp,g,f,e,d,c,b,a}, active low, decimal point off
   localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
   localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
   localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
   localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
   localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
   localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
   localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
   localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
   localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
   localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
   localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // Pre-shift correction so a digit >= 5 carries correctly after doubling
   function automatic logic [DIGIT_W-1:0] bcd_add3(input logic [DIGIT_W-1:0] d);
      return (d >= 4'd5) ? DIGIT_W'(d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/count_bcd_display_if.sv
// Display stage bus: binary count in, four HEX digits plus status out.
interface count_bcd_display_if
   import count_bcd_display_pkg::*;
#(
   parameter int unsigned WIDTH = 10
);
   logic [WIDTH-1:0] value_in;
   logic [SEG_W-1:0] HEX0;
   logic [SEG_W-1:0] HEX1;
   logic [SEG_W-1:0] HEX2;
   logic [SEG_W-1:0] HEX3;
   logic             busy;
   logic             update;

   modport master (
      output value_in,
      input  HEX0, HEX1, HEX2, HEX3, busy, update
   );

   modport slave (
      input  value_in,
      output HEX0, HEX1, HEX2, HEX3, busy, update
   );
endinterface

// File: rtl/count_bcd_display_seg7_decode.sv
// One BCD digit to active-low seven-segment pattern; codes above 9 and
// blanked digits both show nothing.
module seg7_decode
   import count_bcd_display_pkg::*;
(
   input  logic [DIGIT_W-1:0] bcd,
   input  logic               blank,
   output logic [SEG_W-1:0]   seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/count_bcd_display.sv
// Binary count to four seven-segment digits via a bit-serial double-dabble
// converter; a one-cycle stability filter qualifies the asynchronous count.
module count_bcd_display
   import count_bcd_display_pkg::*;
#(
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned DIGITS   = 4,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic MAX10_CLK1_50,
   input  logic KEY0,
   count_bcd_display_if.slave disp
);

   localparam int unsigned BCD_W = DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t                       state_q, state_d;
   logic [WIDTH-1:0]             sample_q;
   logic [WIDTH-1:0]             shown_q, shown_d;
   logic [WIDTH-1:0]             conv_q, conv_d;
   logic [WIDTH-1:0]             bin_q, bin_d;
   logic [BCD_W-1:0]             bcd_q, bcd_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         first_q, first_d;
   logic                         busy_q;
   logic                         update_q;
   logic [DIGITS-1:0][SEG_W-1:0] hex_q, hex_d;

   logic                         stable_c;
   logic                         start_c;
   logic [BCD_W-1:0]             bcd_adj_c;
   logic [DIGITS-1:0]            blank_c;
   logic                         zero_run_c;
   logic [DIGITS-1:0][SEG_W-1:0] seg_c;

   // The count crosses domains as a bus; only accept it once it held for a cycle
   assign stable_c = (disp.value_in == sample_q);
   assign start_c  = stable_c && ((sample_q != shown_q) || first_q);

   always_comb begin
      bcd_adj_c = '0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         bcd_adj_c[DIGIT_W*k +: DIGIT_W] = bcd_add3(bcd_q[DIGIT_W*k +: DIGIT_W]);
      end
   end

   // A digit blanks only when it and every more-significant digit are zero
   always_comb begin
      blank_c    = '0;
      zero_run_c = BLANK_LZ;
      for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
         zero_run_c = zero_run_c && (bcd_q[DIGIT_W*k +: DIGIT_W] == 4'd0);
         blank_c[k] = zero_run_c;
      end
   end

   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
      seg7_decode u_dec (
         .bcd   (bcd_q[DIGIT_W*g +: DIGIT_W]),
         .blank (blank_c[g]),
         .seg_c (seg_c[g])
      );
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      shown_d = shown_q;
      conv_d  = conv_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      hex_d   = hex_q;
      case (state_q)
         IDLE: begin
            if (start_c) begin
               bin_d   = sample_q;
               conv_d  = sample_q;
               bcd_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj_c, bin_q} << 1;
            cnt_d          = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            hex_d   = seg_c;
            shown_d = conv_q;
            first_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
      if (!KEY0) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
      if (!KEY0) begin
         sample_q <= '0;
         shown_q  <= '0;
         conv_q   <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         first_q  <= 1'b1;
         busy_q   <= 1'b0;
         update_q <= 1'b0;
         hex_q    <= {DIGITS{SEG_BLANK}};
      end else begin
         sample_q <= disp.value_in;
         shown_q  <= shown_d;
         conv_q   <= conv_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         first_q  <= first_d;
         busy_q   <= (state_d != IDLE);
         update_q <= (state_d == UPDATE);
         hex_q    <= hex_d;
      end
   end

   assign disp.HEX0   = hex_q[0];
   assign disp.HEX1   = hex_q[1];
   assign disp.HEX2   = hex_q[2];
   assign disp.HEX3   = hex_q[3];
   assign disp.busy   = busy_q;
   assign disp.update = update_q;

endmodule
